// File: rtl/imem_loader.sv
// Boot image loader: framed byte stream -> instruction RAM write port.
// Holds the core in reset until a checksum-verified image is in place.
module imem_loader #(
  parameter int AWIDTH  = 12,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              we,
  output logic [AWIDTH-1:0] addr,
  output logic [DWIDTH-1:0] din,
  output logic              core_hold,
  output logic              done,
  output logic              err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CNT_LO = 3'd1;
  localparam logic [2:0] S_CNT_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CHK    = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  logic [2:0]        state_q, state_d;
  logic              rdy_q, rdy_d;
  logic              we_q, we_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] din_q, din_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [7:0]        sum_q, sum_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [TW-1:0]     tmr_q, tmr_d;

  logic        acc;
  logic        tmo;
  logic        active;
  logic [15:0] n;
  logic [15:0] last;

  assign acc    = rx_valid && rdy_q;
  assign tmo    = !acc && (tmr_q == TW'(TIMEOUT - 1));
  assign active = (state_q == S_CNT_LO) || (state_q == S_CNT_HI) ||
                  (state_q == S_DATA) || (state_q == S_CHK);
  assign n      = {rx_data, cnt_q[7:0]};
  assign last   = cnt_q - 16'd1;

  always_comb begin
    state_d = state_q;
    rdy_d   = 1'b1;
    we_d    = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    bcnt_d  = bcnt_q;
    tmr_d   = tmr_q;

    if (active) tmr_d = acc ? '0 : tmr_q + TW'(1);
    // Advance only after a write that was not the last word.
    if (we_q && state_q == S_DATA) addr_d = addr_q + AWIDTH'(1);

    unique case (state_q)
      S_IDLE: begin
        if (acc && rx_data == 8'hA5) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          hold_d  = 1'b1;
          sum_d   = '0;
          bcnt_d  = '0;
          tmr_d   = '0;
          state_d = S_CNT_LO;
        end
      end
      S_CNT_LO: begin
        if (acc) begin
          cnt_d[7:0] = rx_data;
          state_d    = S_CNT_HI;
        end else if (tmo) begin
          state_d = S_ERR;
        end
      end
      S_CNT_HI: begin
        if (acc) begin
          cnt_d = n;
          if (n == 16'd0 || 32'(n) > (32'd1 << AWIDTH)) begin
            state_d = S_ERR;
          end else begin
            addr_d  = '0;
            state_d = S_DATA;
          end
        end else if (tmo) begin
          state_d = S_ERR;
        end
      end
      S_DATA: begin
        if (acc) begin
          din_d[{bcnt_q, 3'b000} +: 8] = rx_data;
          sum_d  = sum_q + rx_data;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            we_d = 1'b1;
            if (addr_q == AWIDTH'(last)) state_d = S_CHK;
          end
        end else if (tmo) begin
          state_d = S_ERR;
        end
      end
      S_CHK: begin
        if (acc) begin
          state_d = (rx_data == sum_q) ? S_DONE : S_ERR;
        end else if (tmo) begin
          state_d = S_ERR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_DONE && state_q != S_DONE) begin
      done_d = 1'b1;
      hold_d = 1'b0;
    end
    if (state_d == S_ERR && state_q != S_ERR) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rdy_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      bcnt_q  <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      bcnt_q  <= bcnt_d;
      tmr_q   <= tmr_d;
    end
  end

  assign rx_ready  = rdy_q;
  assign we        = we_q;
  assign addr      = addr_q;
  assign din       = din_q;
  assign core_hold = hold_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framing, checksum, bounds,
// timeout, resync filtering, mid-frame reset and throttled input.
module tb_imem_loader;

  localparam int AW = 12;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          we;
  logic [AW-1:0] addr;
  logic [31:0]   din;
  logic          core_hold;
  logic          done;
  logic          err;

  int checks = 0;
  int errors = 0;

  logic [AW+31:0] wq[$];

  imem_loader #(.AWIDTH(AW), .DWIDTH(32), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .we        (we),
    .addr      (addr),
    .din       (din),
    .core_hold (core_hold),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (we) wq.push_back({addr, din});
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    tick(gap);
  endtask

  task automatic frame2(input logic [7:0] ck, input int maxgap);
    logic [7:0] f[12];
    f = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00,
          8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, ck};
    for (int i = 0; i < 12; i++)
      send(f[i], (maxgap == 0) ? 0 : int'($urandom_range(maxgap, 0)));
    tick(3);
  endtask

  task automatic chk_writes2(input string tag);
    chk({tag, "_nwr"}, 64'(wq.size()), 64'd2);
    if (wq.size() == 2) begin
      chk({tag, "_w0"}, 64'(wq[0]), {20'd0, 12'h000, 32'h13});
      chk({tag, "_w1"}, 64'(wq[1]), {20'd0, 12'h001, 32'h6F});
    end
  endtask

  initial begin
    logic [7:0] sum;
    rst      = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    tick(3);
    chk("rst_ready", 64'(rx_ready), 64'd0);
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_addr", 64'(addr), 64'd0);
    chk("rst_din", 64'(din), 64'd0);
    chk("rst_hold", 64'(core_hold), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rx_valid = 1'b0;
    rst      = 1'b0;
    tick(1);
    chk("ready_up", 64'(rx_ready), 64'd1);

    // Sync filter, then good frame with exact write timing.
    send(8'h00, 0);
    send(8'hFF, 0);
    send(8'h5A, 0);
    tick(2);
    send(8'hA5, 0);
    send(8'h02, 0);
    send(8'h00, 0);
    send(8'h13, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    chk("pre_we", 64'(we), 64'd0);
    send(8'h00, 0);
    chk("we_t1", 64'(we), 64'd1);
    chk("we_t1_addr", 64'(addr), 64'd0);
    chk("we_t1_din", 64'(din), 64'h13);
    send(8'h6F, 0);
    chk("we_pulse", 64'(we), 64'd0);
    chk("addr_inc", 64'(addr), 64'd1);
    send(8'h00, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    chk("we2_t1", 64'(we), 64'd1);
    chk("hold_busy", 64'(core_hold), 64'd1);
    send(8'h82, 0);
    tick(3);
    chk_writes2("good");
    chk("good_done", 64'(done), 64'd1);
    chk("good_hold", 64'(core_hold), 64'd0);
    chk("good_err", 64'(err), 64'd0);

    wq.delete();
    frame2(8'h83, 0);
    chk_writes2("badck");
    chk("badck_err", 64'(err), 64'd1);
    chk("badck_done", 64'(done), 64'd0);
    chk("badck_hold", 64'(core_hold), 64'd1);

    wq.delete();
    send(8'hA5, 0);
    chk("sync_clr_err", 64'(err), 64'd0);
    send(8'h00, 0);
    send(8'h00, 0);
    tick(3);
    chk("n0_err", 64'(err), 64'd1);
    chk("n0_nwr", 64'(wq.size()), 64'd0);

    send(8'hA5, 0);
    send(8'h01, 0);
    send(8'h10, 0);
    tick(3);
    chk("n4097_err", 64'(err), 64'd1);
    chk("n4097_nwr", 64'(wq.size()), 64'd0);

    // Timeout: 15 idle cycles are tolerated, the 16th aborts.
    send(8'hA5, 0);
    send(8'h01, 0);
    send(8'h00, 0);
    send(8'hAA, 0);
    send(8'hBB, 0);
    tick(15);
    chk("tmo_early", 64'(err), 64'd0);
    tick(1);
    chk("tmo_err", 64'(err), 64'd1);
    tick(3);
    chk("tmo_nwr", 64'(wq.size()), 64'd0);
    frame2(8'h82, 0);
    chk_writes2("post_tmo");
    chk("post_tmo_done", 64'(done), 64'd1);

    // Mid-frame reset after two data bytes.
    wq.delete();
    send(8'hA5, 0);
    send(8'h02, 0);
    send(8'h00, 0);
    send(8'h13, 0);
    send(8'h00, 0);
    rst = 1'b1;
    tick(1);
    chk("mrst_ready", 64'(rx_ready), 64'd0);
    chk("mrst_hold", 64'(core_hold), 64'd1);
    chk("mrst_done", 64'(done), 64'd0);
    chk("mrst_addr", 64'(addr), 64'd0);
    chk("mrst_din", 64'(din), 64'd0);
    rst = 1'b0;
    tick(2);
    chk("mrst_nwr", 64'(wq.size()), 64'd0);
    frame2(8'h82, 0);
    chk_writes2("post_rst");
    chk("post_rst_done", 64'(done), 64'd1);

    // Full-depth image: N = 4096, word i = i.
    wq.delete();
    sum = 8'h00;
    send(8'hA5, 0);
    send(8'h00, 0);
    send(8'h10, 0);
    for (int i = 0; i < 4096; i++) begin
      logic [15:0] w;
      w = 16'(i);
      send(w[7:0], 0);
      send(w[15:8], 0);
      send(8'h00, 0);
      send(8'h00, 0);
      sum = sum + w[7:0] + w[15:8];
    end
    send(sum, 0);
    tick(3);
    chk("full_nwr", 64'(wq.size()), 64'd4096);
    if (wq.size() > 0)
      chk("full_last", 64'(wq[$]), {20'd0, 12'hFFF, 32'h00000FFF});
    chk("full_done", 64'(done), 64'd1);
    chk("full_err", 64'(err), 64'd0);

    wq.delete();
    frame2(8'h82, 10);
    chk_writes2("throttle");
    chk("throttle_done", 64'(done), 64'd1);
    chk("throttle_hold", 64'(core_hold), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
